// File: rtl/dac_segment_encoder.sv
// Segmented-DAC front end: splits a code into a binary LSB word and a thermometer MSB word,
// with optional element rotation and a pdb power sequence around the live data window.
module dac_segment_encoder #(
  parameter int BIN_BITS   = 7,
  parameter int THERM_SEGS = 17,
  parameter int CODE_W     = 12,
  parameter int MAX_CODE   = 2303,
  parameter int PU_WAIT    = 8,
  parameter int PD_WAIT    = 2
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  enable,
  input  logic                  code_valid,
  input  logic [CODE_W-1:0]     code,
  input  logic                  dem_en,
  output logic                  ready,
  output logic                  pdb,
  output logic [BIN_BITS-1:0]   datain,
  output logic [BIN_BITS-1:0]   datainb,
  output logic [THERM_SEGS-1:0] datatherm,
  output logic [THERM_SEGS-1:0] datathermb,
  output logic                  sat_flag
);

  localparam int CNT_W = $clog2(PU_WAIT + PD_WAIT + 1);
  localparam int M_W   = $clog2(THERM_SEGS + 1);
  localparam int PTR_W = $clog2(THERM_SEGS);
  localparam int SUM_W = ((PTR_W > M_W) ? PTR_W : M_W) + 1;
  localparam logic [CODE_W-1:0] MAX_C = CODE_W'(MAX_CODE);

  typedef enum logic [1:0] {S_OFF, S_PWRUP, S_ACTIVE, S_PWRDN} state_t;

  // Handshake: a code is taken on a rising edge where ready and code_valid are both high;
  // ready is registered and only ever high in ACTIVE.
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d, pdb_q, pdb_d;
  logic                  s1_vld_q, s1_vld_d, s1_sat_q, s1_sat_d, s1_dem_q, s1_dem_d;
  logic [BIN_BITS-1:0]   s1_bin_q, s1_bin_d;
  logic [M_W-1:0]        s1_m_q, s1_m_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [BIN_BITS-1:0]   datain_q, datain_d, datainb_q, datainb_d;
  logic [THERM_SEGS-1:0] therm_q, therm_d, thermb_q, thermb_d;
  logic                  sat_q, sat_d;

  logic                      accept, code_sat;
  logic [CODE_W-1:0]         code_c;
  logic [THERM_SEGS:0]       fill_ext;
  logic [THERM_SEGS-1:0]     fill, therm_new;
  logic [2*THERM_SEGS-1:0]   dbl;
  logic [SUM_W-1:0]          ptr_sum;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (enable) state_d = S_PWRUP;
      end
      S_PWRUP: begin
        if (!enable) begin
          state_d = S_PWRDN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(PU_WAIT - 1)) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!enable) begin
          state_d = S_PWRDN;
          cnt_d   = '0;
        end
      end
      default: begin
        // Power-down always runs to completion, even if enable comes back.
        if (cnt_q == CNT_W'(PD_WAIT - 1)) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    ready_d = (state_d == S_ACTIVE);
    pdb_d   = (state_d != S_OFF);
  end

  // Stage 1: clamp and split. dem_en travels with its code.
  always_comb begin
    accept   = ready_q & code_valid;
    code_sat = (code > MAX_C);
    code_c   = code_sat ? MAX_C : code;
    s1_vld_d = accept & (state_d == S_ACTIVE);
    s1_bin_d = s1_bin_q;
    s1_m_d   = s1_m_q;
    s1_sat_d = s1_sat_q;
    s1_dem_d = s1_dem_q;
    if (accept) begin
      s1_bin_d = code_c[BIN_BITS-1:0];
      s1_m_d   = code_c[BIN_BITS +: M_W];
      s1_sat_d = code_sat;
      s1_dem_d = dem_en;
    end
  end

  // Stage 2: fill m elements, rotated by ptr when DEM is on.
  always_comb begin
    fill_ext  = ({{THERM_SEGS{1'b0}}, 1'b1} << s1_m_q) - {{THERM_SEGS{1'b0}}, 1'b1};
    fill      = fill_ext[THERM_SEGS-1:0];
    dbl       = {fill, fill} << ptr_q;
    therm_new = s1_dem_q ? dbl[2*THERM_SEGS-1:THERM_SEGS] : fill;
    ptr_sum   = SUM_W'(ptr_q) + SUM_W'(s1_m_q);
    if (ptr_sum >= SUM_W'(THERM_SEGS)) ptr_sum = ptr_sum - SUM_W'(THERM_SEGS);

    datain_d  = datain_q;
    datainb_d = datainb_q;
    therm_d   = therm_q;
    thermb_d  = thermb_q;
    sat_d     = 1'b0;
    ptr_d     = ptr_q;
    if (state_d != S_ACTIVE) begin
      datain_d  = '0;
      datainb_d = '1;
      therm_d   = '0;
      thermb_d  = '1;
      if (state_d == S_OFF) ptr_d = '0;
    end else if (s1_vld_q) begin
      datain_d  = s1_bin_q;
      datainb_d = ~s1_bin_q;
      therm_d   = therm_new;
      thermb_d  = ~therm_new;
      sat_d     = s1_sat_q;
      if (s1_dem_q) ptr_d = PTR_W'(ptr_sum);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      pdb_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_bin_q  <= '0;
      s1_m_q    <= '0;
      s1_sat_q  <= 1'b0;
      s1_dem_q  <= 1'b0;
      ptr_q     <= '0;
      datain_q  <= '0;
      datainb_q <= '1;
      therm_q   <= '0;
      thermb_q  <= '1;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      pdb_q     <= pdb_d;
      s1_vld_q  <= s1_vld_d;
      s1_bin_q  <= s1_bin_d;
      s1_m_q    <= s1_m_d;
      s1_sat_q  <= s1_sat_d;
      s1_dem_q  <= s1_dem_d;
      ptr_q     <= ptr_d;
      datain_q  <= datain_d;
      datainb_q <= datainb_d;
      therm_q   <= therm_d;
      thermb_q  <= thermb_d;
      sat_q     <= sat_d;
    end
  end

  assign ready      = ready_q;
  assign pdb        = pdb_q;
  assign datain     = datain_q;
  assign datainb    = datainb_q;
  assign datatherm  = therm_q;
  assign datathermb = thermb_q;
  assign sat_flag   = sat_q;

endmodule
